// File: rtl/ahb_input_stage_dma_pkg.sv
// Shared bus-matrix constants and types: HTRANS/HBURST/HRESP encodings and
// the bundle of address-phase controls captured by the input stage.
package ahb_input_stage_dma_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [2:0] HburstSingle = 3'b000;
    localparam logic [2:0] HburstIncr   = 3'b001;
    localparam logic [2:0] HburstWrap4  = 3'b010;
    localparam logic [2:0] HburstIncr4  = 3'b011;
    localparam logic [2:0] HburstWrap8  = 3'b100;
    localparam logic [2:0] HburstIncr8  = 3'b101;
    localparam logic [2:0] HburstWrap16 = 3'b110;
    localparam logic [2:0] HburstIncr16 = 3'b111;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    // Address-phase controls other than the address itself
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } ahb_ctrl_t;

endpackage

// File: rtl/ahb_input_stage_dma_if.sv
// Bus bundle of one matrix input stage: master-side address phase, arbiter
// grant/response from the output side, and the muxed request toward the decoder.
interface ahb_input_stage_dma_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  active_trans;
    logic                  HREADYM;
    logic                  HRESPM;

    logic                  sel_trans;
    logic [ADDR_WIDTH-1:0] HADDRI;
    logic [1:0]            HTRANSI;
    logic                  HWRITEI;
    logic [2:0]            HSIZEI;
    logic [2:0]            HBURSTI;
    logic [3:0]            HPROTI;
    logic                  HMASTLOCKI;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // Input stage view
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
        input  HREADYS, active_trans, HREADYM, HRESPM,
        output sel_trans, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
        output HREADYOUTS, HRESPS
    );

    // Environment view (master plus output-stage side)
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
        output HREADYS, active_trans, HREADYM, HRESPM,
        input  sel_trans, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
        input  HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/ahb_hold_reg.sv
// Capture register for a stalled address phase plus the held/live output mux.
module ahb_hold_reg
    import ahb_input_stage_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic                  pend,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] addr_live,
    input  ahb_ctrl_t             ctrl_live,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output ahb_ctrl_t             ctrl_out
);

    logic [ADDR_WIDTH-1:0] addr_q;
    ahb_ctrl_t             ctrl_q;

    // Latch the address phase the arbiter could not take this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            ctrl_q <= '0;
        end else if (capture) begin
            addr_q <= addr_live;
            ctrl_q <= ctrl_live;
        end
    end

    // Held transfer is replayed verbatim; live one is masked to IDLE when unselected
    always_comb begin
        addr_out = addr_live;
        ctrl_out = ctrl_live;
        if (pend) begin
            addr_out = addr_q;
            ctrl_out = ctrl_q;
        end else if (!sel) begin
            ctrl_out.trans = HtransIdle;
        end
    end

endmodule

// File: rtl/ahb_input_stage_dma.sv
// Per-master input stage of the DMA bus matrix: holds address phases the
// output arbiter cannot accept, stalls the master meanwhile and returns the
// data-phase response of whichever output port owns this master's transfer.
module ahb_input_stage_dma
    import ahb_input_stage_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                  HCLK,
    input logic                  HRESET,
    ahb_input_stage_dma_if.slave bus
);

    logic      new_trans;
    logic      grant;
    logic      capture;
    logic      pend_q, pend_d;
    logic      dip_q, dip_d;
    ahb_ctrl_t ctrl_live;
    ahb_ctrl_t ctrl_out;

    assign new_trans = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    assign grant     = bus.active_trans & bus.HREADYM;
    // While pend is set the master is stalled, so new_trans cannot overlap it
    assign capture   = new_trans & ~grant;

    // Bundle live controls for the hold register
    always_comb begin
        ctrl_live       = '0;
        ctrl_live.trans = bus.HTRANSS;
        ctrl_live.write = bus.HWRITES;
        ctrl_live.size  = bus.HSIZES;
        ctrl_live.burst = bus.HBURSTS;
        ctrl_live.prot  = bus.HPROTS;
        ctrl_live.lock  = bus.HMASTLOCKS;
    end

    ahb_hold_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold_reg (
        .clk       (HCLK),
        .rst       (HRESET),
        .capture   (capture),
        .pend      (pend_q),
        .sel       (bus.HSELS),
        .addr_live (bus.HADDRS),
        .ctrl_live (ctrl_live),
        .addr_out  (bus.HADDRI),
        .ctrl_out  (ctrl_out)
    );

    assign bus.HTRANSI    = ctrl_out.trans;
    assign bus.HWRITEI    = ctrl_out.write;
    assign bus.HSIZEI     = ctrl_out.size;
    assign bus.HBURSTI    = ctrl_out.burst;
    assign bus.HPROTI     = ctrl_out.prot;
    assign bus.HMASTLOCKI = ctrl_out.lock;

    // Pending-request and data-in-progress flags
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q <= 1'b0;
            dip_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dip_q  <= dip_d;
        end
    end

    // Next state: pend tracks an ungranted request, dip tracks output-side data ownership
    always_comb begin
        pend_d = pend_q;
        dip_d  = dip_q;
        if (capture) begin
            pend_d = 1'b1;
        end else if (grant) begin
            pend_d = 1'b0;
        end
        if ((pend_q | new_trans) & grant) begin
            dip_d = 1'b1;
        end else if (bus.HREADYM) begin
            dip_d = 1'b0;
        end
    end

    // Master-side handshake and request toward the arbiters
    always_comb begin
        bus.sel_trans  = pend_q | new_trans;
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = HrespOkay;
        if (dip_q) begin
            bus.HREADYOUTS = bus.HREADYM;
            bus.HRESPS     = bus.HRESPM;
        end else if (pend_q) begin
            bus.HREADYOUTS = 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_input_stage_dma.sv
// Self-checking bench for ahb_input_stage_dma: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ahb_input_stage_dma;
    import ahb_input_stage_dma_pkg::*;

    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahb_input_stage_dma_if #(.ADDR_WIDTH(AW)) bus ();

    ahb_input_stage_dma #(
        .ADDR_WIDTH (AW)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          lock;
    } xfer_t;

    task automatic set_idle();
        bus.HSELS = 1'b0; bus.HADDRS = '0; bus.HTRANSS = HtransIdle; bus.HWRITES = 1'b0;
        bus.HSIZES = 3'd2; bus.HBURSTS = HburstSingle; bus.HPROTS = 4'h0;
        bus.HMASTLOCKS = 1'b0; bus.HREADYS = 1'b1; bus.active_trans = 1'b0;
        bus.HREADYM = 1'b1; bus.HRESPM = 1'b0;
    endtask

    task automatic drive_addr(input logic [AW-1:0] a, input logic [1:0] t, input logic [2:0] b);
        bus.HSELS = 1'b1; bus.HREADYS = 1'b1; bus.HADDRS = a; bus.HTRANSS = t; bus.HBURSTS = b;
    endtask

    task automatic test_reset();
        set_idle();
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", bus.HREADYOUTS); end
        checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL rst_sel: got %0b want 0", bus.sel_trans); end
        checks++; if (bus.HRESPS !== 1'b0) begin errors++; $display("FAIL rst_resp: got %0b want 0", bus.HRESPS); end
        checks++; if (bus.HTRANSI !== HtransIdle) begin errors++; $display("FAIL rst_trans: got %0d want 0", bus.HTRANSI); end
        @(negedge clk); rst = 1'b0;
        // Build a hold, then reset in the middle of it
        @(negedge clk); set_idle(); drive_addr(32'h1000_0040, HtransNonseq, HburstSingle);
        #1;
        checks++; if (bus.sel_trans !== 1'b1) begin errors++; $display("FAIL rsthold_sel: got %0b want 1", bus.sel_trans); end
        @(negedge clk); bus.HTRANSS = HtransIdle; bus.HREADYS = 1'b0; bus.HADDRS = 32'hdead_beef;
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL rsthold_ready: got %0b want 0", bus.HREADYOUTS); end
        checks++; if (bus.HADDRI !== 32'h1000_0040) begin errors++; $display("FAIL rsthold_addr: got %h want 10000040", bus.HADDRI); end
        rst = 1'b1;
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b want 1", bus.HREADYOUTS); end
        checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL rstmid_sel: got %0b want 0", bus.sel_trans); end
        checks++; if (bus.HTRANSI !== HtransIdle) begin errors++; $display("FAIL rstmid_trans: got %0d want 0", bus.HTRANSI); end
        @(negedge clk); rst = 1'b0; set_idle(); bus.active_trans = 1'b1;
        #1;
        checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL ghost_sel: got %0b want 0", bus.sel_trans); end
        checks++; if (bus.HADDRI !== 32'h0) begin errors++; $display("FAIL ghost_addr: got %h want 0", bus.HADDRI); end
        @(negedge clk); #1;
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL ghost_ready: got %0b want 1", bus.HREADYOUTS); end
    endtask

    task automatic test_immediate_grant();
        @(negedge clk); set_idle(); drive_addr(32'h2000_0000, HtransNonseq, HburstSingle);
        bus.HWRITES = 1'b1; bus.active_trans = 1'b1;
        #1;
        checks++; if (bus.HADDRI !== 32'h2000_0000) begin errors++; $display("FAIL imm_addr: got %h want 20000000", bus.HADDRI); end
        checks++; if (bus.HTRANSI !== HtransNonseq) begin errors++; $display("FAIL imm_trans: got %0d want 2", bus.HTRANSI); end
        checks++; if (bus.HWRITEI !== 1'b1) begin errors++; $display("FAIL imm_write: got %0b want 1", bus.HWRITEI); end
        @(negedge clk); set_idle(); bus.HREADYM = 1'b0;
        #1;
        checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL imm_nopend: got %0b want 0", bus.sel_trans); end
        checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL imm_track0: got %0b want 0", bus.HREADYOUTS); end
        @(negedge clk); bus.HREADYM = 1'b1;
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL imm_track1: got %0b want 1", bus.HREADYOUTS); end
        @(negedge clk); set_idle();
    endtask

    task automatic test_held();
        @(negedge clk); set_idle(); drive_addr(32'h1000_0040, HtransNonseq, HburstSingle);
        bus.HMASTLOCKS = 1'b1;
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL held_c0_ready: got %0b want 1", bus.HREADYOUTS); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            // Master deselects and changes bus while stalled; held values must persist
            bus.HSELS = 1'b0; bus.HREADYS = 1'b0; bus.HADDRS = $urandom; bus.HMASTLOCKS = 1'b0;
            bus.HTRANSS = HtransIdle; bus.active_trans = (i == 3);
            #1;
            checks++; if (bus.HADDRI !== 32'h1000_0040) begin errors++; $display("FAIL held_addr c%0d: got %h want 10000040", i, bus.HADDRI); end
            checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL held_ready c%0d: got %0b want 0", i, bus.HREADYOUTS); end
            checks++; if (bus.HMASTLOCKI !== 1'b1) begin errors++; $display("FAIL held_lock c%0d: got %0b want 1", i, bus.HMASTLOCKI); end
            checks++; if (bus.HTRANSI !== HtransNonseq) begin errors++; $display("FAIL held_trans c%0d: got %0d want 2", i, bus.HTRANSI); end
        end
        @(negedge clk); set_idle();
        #1;
        checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL held_cleared: got %0b want 0", bus.sel_trans); end
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL held_done: got %0b want 1", bus.HREADYOUTS); end
    endtask

    task automatic test_burst();
        logic [AW-1:0] granted[$];
        logic [AW-1:0] base;
        base = 32'h4000_0100;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); set_idle();
            case (c)
                0: begin drive_addr(base, HtransNonseq, HburstIncr4); bus.active_trans = 1'b1; end
                1: begin drive_addr(base + 4, HtransSeq, HburstIncr4); bus.active_trans = 1'b1; end
                2: begin drive_addr(base + 8, HtransSeq, HburstIncr4); end
                3: begin drive_addr(base + 12, HtransSeq, HburstIncr4); bus.HREADYS = 1'b0; end
                4: begin drive_addr(base + 12, HtransSeq, HburstIncr4); bus.HREADYS = 1'b0;
                          bus.active_trans = 1'b1; end
                5: begin drive_addr(base + 12, HtransSeq, HburstIncr4); bus.active_trans = 1'b1; end
                default: ;
            endcase
            #1;
            if (c == 3) begin
                checks++; if (bus.HTRANSI !== HtransSeq) begin errors++; $display("FAIL burst_trans: got %0d want 3", bus.HTRANSI); end
                checks++; if (bus.HBURSTI !== HburstIncr4) begin errors++; $display("FAIL burst_hburst: got %0d want 3", bus.HBURSTI); end
                checks++; if (bus.HADDRI !== base + 8) begin errors++; $display("FAIL burst_addr: got %h want %h", bus.HADDRI, base + 8); end
                checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL burst_stall: got %0b want 0", bus.HREADYOUTS); end
            end
            if (c == 5) begin
                checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL burst_resume: got %0b want 1", bus.HREADYOUTS); end
            end
            if (bus.sel_trans && bus.active_trans && bus.HREADYM) granted.push_back(bus.HADDRI);
        end
        checks++; if (granted.size() != 4) begin errors++; $display("FAIL burst_beats: got %0d want 4", granted.size()); end
        for (int i = 0; i < 4 && i < granted.size(); i++) begin
            checks++; if (granted[i] !== base + 4 * i) begin errors++; $display("FAIL burst_order %0d: got %h want %h", i, granted[i], base + 4 * i); end
        end
    endtask

    task automatic test_error();
        @(negedge clk); set_idle(); drive_addr(32'h3000_0100, HtransNonseq, HburstSingle);
        @(negedge clk); set_idle(); bus.HREADYS = 1'b0; bus.active_trans = 1'b1;
        #1;
        checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL err_grant_ready: got %0b want 0", bus.HREADYOUTS); end
        @(negedge clk); set_idle(); bus.HREADYM = 1'b0; bus.HRESPM = HrespError;
        #1;
        checks++; if (bus.HRESPS !== HrespError) begin errors++; $display("FAIL err_resp1: got %0b want 1", bus.HRESPS); end
        checks++; if (bus.HREADYOUTS !== 1'b0) begin errors++; $display("FAIL err_ready1: got %0b want 0", bus.HREADYOUTS); end
        @(negedge clk); bus.HREADYM = 1'b1; bus.HRESPM = HrespError;
        #1;
        checks++; if (bus.HRESPS !== HrespError) begin errors++; $display("FAIL err_resp2: got %0b want 1", bus.HRESPS); end
        checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL err_ready2: got %0b want 1", bus.HREADYOUTS); end
        @(negedge clk); set_idle(); bus.HRESPM = HrespError;
        #1;
        checks++; if (bus.HRESPS !== HrespOkay) begin errors++; $display("FAIL err_after: got %0b want 0", bus.HRESPS); end
    endtask

    task automatic test_idle_busy();
        logic [1:0] tl [2];
        tl[0] = HtransIdle;
        tl[1] = HtransBusy;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); set_idle(); drive_addr(32'h5000_0000, tl[i], HburstIncr);
            #1;
            checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL ib_sel %0d: got %0b want 0", i, bus.sel_trans); end
            checks++; if (bus.HTRANSI !== tl[i]) begin errors++; $display("FAIL ib_trans %0d: got %0d want %0d", i, bus.HTRANSI, tl[i]); end
            @(negedge clk); set_idle();
            #1;
            checks++; if (bus.HREADYOUTS !== 1'b1) begin errors++; $display("FAIL ib_ready %0d: got %0b want 1", i, bus.HREADYOUTS); end
            checks++; if (bus.sel_trans !== 1'b0) begin errors++; $display("FAIL ib_nopend %0d: got %0b want 0", i, bus.sel_trans); end
        end
    endtask

    task automatic test_random();
        bit    m_pend;
        bit    m_owned;
        xfer_t m_held;
        xfer_t live;
        bit    nt;
        bit    won;
        xfer_t e;
        bit    e_sel, e_ready, e_resp;
        @(negedge clk); set_idle(); rst = 1'b1;
        #2 rst = 1'b0;
        m_pend = 1'b0; m_owned = 1'b0;
        m_held = '{addr: '0, trans: 2'b0, write: 1'b0, size: 3'b0, burst: 3'b0, prot: 4'b0, lock: 1'b0};
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            live.addr = $urandom; live.trans = 2'($urandom); live.write = 1'($urandom);
            live.size = 3'($urandom); live.burst = 3'($urandom); live.prot = 4'($urandom);
            live.lock = 1'($urandom);
            bus.HSELS = ($urandom_range(0, 3) != 0);
            bus.HADDRS = live.addr; bus.HTRANSS = live.trans; bus.HWRITES = live.write;
            bus.HSIZES = live.size; bus.HBURSTS = live.burst; bus.HPROTS = live.prot;
            bus.HMASTLOCKS = live.lock;
            // A stalled master cannot present a new address phase
            bus.HREADYS = m_pend ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.active_trans = 1'($urandom);
            bus.HREADYM = ($urandom_range(0, 3) != 0);
            bus.HRESPM = ($urandom_range(0, 3) == 0);
            nt = bus.HSELS && bus.HREADYS && (live.trans == HtransNonseq || live.trans == HtransSeq);
            won = bus.active_trans && bus.HREADYM;
            e = m_pend ? m_held : live;
            if (!m_pend && !bus.HSELS) e.trans = HtransIdle;
            e_sel = m_pend || nt;
            e_ready = m_owned ? bus.HREADYM : !m_pend;
            e_resp = m_owned ? bus.HRESPM : HrespOkay;
            #1;
            checks++; if (bus.sel_trans !== e_sel) begin errors++; $display("FAIL rnd_sel c%0d: got %0b want %0b", c, bus.sel_trans, e_sel); end
            checks++; if (bus.HADDRI !== e.addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.HADDRI, e.addr); end
            checks++; if (bus.HTRANSI !== e.trans) begin errors++; $display("FAIL rnd_trans c%0d: got %0d want %0d", c, bus.HTRANSI, e.trans); end
            checks++; if ({bus.HWRITEI, bus.HSIZEI, bus.HBURSTI, bus.HPROTI, bus.HMASTLOCKI} !== {e.write, e.size, e.burst, e.prot, e.lock}) begin
                errors++; $display("FAIL rnd_ctrl c%0d: got %h want %h", c,
                    {bus.HWRITEI, bus.HSIZEI, bus.HBURSTI, bus.HPROTI, bus.HMASTLOCKI},
                    {e.write, e.size, e.burst, e.prot, e.lock});
            end
            checks++; if (bus.HREADYOUTS !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, bus.HREADYOUTS, e_ready); end
            checks++; if (bus.HRESPS !== e_resp) begin errors++; $display("FAIL rnd_resp c%0d: got %0b want %0b", c, bus.HRESPS, e_resp); end
            // Advance the reference: ownership passes on an accepted request, ends on ready
            if (e_sel && won) m_owned = 1'b1;
            else if (bus.HREADYM) m_owned = 1'b0;
            if (nt && !won) begin
                m_held = live;
                m_pend = 1'b1;
            end else if (won) begin
                m_pend = 1'b0;
            end
        end
        @(negedge clk); set_idle();
    endtask

    initial begin
        test_reset();
        test_immediate_grant();
        test_held();
        test_burst();
        test_error();
        test_idle_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_input_stage_dma.md
Name: ahb_input_stage_dma

Overview:
- Per-master input stage of the DMA bus matrix. It sits between one master-side slave port and the decoder/output arbiters.
- Captures an address phase that the target output port cannot accept immediately. Holds it as a pending request (the source of the arbiters' req_portN) until granted.
- Stalls the master with wait states while its transfer is held.
- Returns data-phase responses from the selected output port.

Parameters:
- ADDR_WIDTH, 32, width of HADDRS/HADDRI.

Ports:
- HCLK  in  1  AHB system clock
- HRESET  in  1  reset, asynchronous, active-high
- HSELS  in  1  slave select from master side
- HADDRS  in  ADDR_WIDTH  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst type
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  lock
- HREADYS  in  1  global ready on master side
- active_trans  in  1  output arbiter has this port selected as address source this cycle
- HREADYM  in  1  ready of output port currently carrying this port's data phase
- HRESPM  in  1  response of that output port
- sel_trans  out  1  valid transfer request toward decoder/arbiters
- HADDRI  out  ADDR_WIDTH  muxed (held or live) address
- HTRANSI  out  2  muxed transfer type
- HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI  out  1/3/3/4/1  muxed controls
- HREADYOUTS  out  1  ready to master
- HRESPS  out  1  response to master

Behaviour:
- Only clock: HCLK. Only reset: HRESET, asynchronous, active-high. All flops clear on HRESET rising, independent of HCLK.
- new_trans = HSELS & HREADYS & HTRANSS[1]. NONSEQ/SEQ count; IDLE/BUSY are never captured.
- Hold register: on new_trans & ~(active_trans & HREADYM), capture ADDR/TRANS/WRITE/SIZE/BURST/PROT/LOCK; set pend=1.
- pend clears on active_trans & HREADYM. A simultaneous new_trans is impossible while pend=1, since HREADYOUTS=0 then.
- sel_trans = pend | new_trans (combinational).
- Address mux: pend ? held regs : live inputs. HTRANSI = pend ? held : (HSELS ? HTRANSS : IDLE). Held transfers are emitted unmodified.
- data_in_prog flag (output stage owns this master's data phase):
  - set when (pend|new_trans) & active_trans & HREADYM
  - else cleared when HREADYM
  - else held
- HREADYOUTS:
  - data_in_prog=1 → HREADYM
  - data_in_prog=0, pend=1 → 0
  - data_in_prog=0, pend=0 → 1
- HRESPS = data_in_prog ? HRESPM : OKAY(0). The two-cycle ERROR passes through unchanged.
- Reset values: pend=0, data_in_prog=0, hold regs=0, HREADYOUTS=1, HRESPS=0, sel_trans=0, HTRANSI=IDLE.
- Latency:
  - granted in the same cycle → 0 wait states added
  - not granted → 1 wait state per cycle until grant
- Boundaries:
  - HSELS deasserted while pend → pending transfer still completes (master already committed).
  - Reset mid-hold → pending transfer discarded.
  - ERROR on held transfer's data phase → pass through; no retry.
  - Locked sequences: HMASTLOCKI follows held value so the arbiter keeps the lock.

Decomposition:
- Shared bus-matrix package: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HBURST encodings, HRESP OKAY/ERROR. The arbiters use the same constants.
- One natural sub-module: ahb_hold_reg, the capture register plus output mux, parameterised by ADDR_WIDTH.
- FSM (pend, data_in_prog) stays in the top.

Test Plan:
- Reset: HRESET=1 mid-hold with pend=1 → immediately HREADYOUTS=1, sel_trans=0, HTRANSI=IDLE; after release, no ghost transfer.
- Immediate grant: NONSEQ 0x2000_0000 with active_trans=1, HREADYM=1 → pend stays 0, HADDRI=0x2000_0000 same cycle, next-cycle HREADYOUTS tracks HREADYM.
- Held transfer: NONSEQ 0x1000_0040 with active_trans=0 for 3 cycles, then 1 → HADDRI=0x1000_0040 throughout, HREADYOUTS=0 for 3 cycles, pend clears on grant, then data phase completes.
- Burst: INCR4 with grant lost after beat 2 → beat-3 SEQ held and re-issued with HTRANSI=SEQ, HBURSTI=INCR4; all 4 beats complete in order.
- Error: HRESPM=1 with HREADYM=0 then 1 on a held transfer → HRESPS=1 both cycles, HREADYOUTS=0 then 1.
- IDLE/BUSY with HSELS=1 and active_trans=0 → pend stays 0, HREADYOUTS=1, sel_trans=0.
